// File: rtl/pong_pkg.sv
// ============================================================================
// pong_pkg : shared types, constants and helpers for the pong score keeper
// Revision : 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int              SCORE_W   = 7;
  localparam logic [3:0]      BCD_MAX   = 4'd9;
  localparam logic [SCORE_W-1:0] SCORE_SAT = 7'd99;

  // Score after one point, pinned at the two-digit ceiling.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v >= SCORE_SAT) ? SCORE_SAT : v + 7'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2_counter.sv
// ============================================================================
// bcd2_counter : two-digit BCD counter with a parallel binary value,
//                synchronous clear, increment enable, saturating at 99
// Revision     : 1.0
// ============================================================================
`default_nettype none

module bcd2_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               inc,
  output logic [3:0]         tens,
  output logic [3:0]         ones,
  output logic [SCORE_W-1:0] value
);

  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;
  logic [SCORE_W-1:0] value_q, value_d;

  always_comb begin
    tens_d  = tens_q;
    ones_d  = ones_q;
    value_d = value_q;
    if (clr) begin
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      value_d = '0;
    end else if (inc && (value_q != SCORE_SAT)) begin
      value_d = value_q + 7'd1;
      if (ones_q == BCD_MAX) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      value_q <= '0;
    end else begin
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      value_q <= value_d;
    end
  end

  assign tens  = tens_q;
  assign ones  = ones_q;
  assign value = value_q;

endmodule

`default_nettype wire

// File: rtl/pong_score_keeper.sv
// ============================================================================
// pong_score_keeper : score keeping, serve delay and game-over sequencing
//                     for two players; BCD digits feed the text overlay.
//                     Optional macro PONG_DEUCE_EN adds a two-point lead rule.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module pong_score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       new_game,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       serve_en,
  output logic       game_over,
  output logic       winner
);

  localparam int                 HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               p1_q, p2_q;
  logic               serve_en_q, serve_en_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;

  logic               p1_edge, p2_edge;
  logic               clr, p1_inc, p2_inc;
  logic [SCORE_W-1:0] p1_val, p2_val;
  logic [SCORE_W-1:0] s1_new, s2_new, mine;
  logic               win;
`ifdef PONG_DEUCE_EN
  logic [SCORE_W-1:0] opp;
`endif

  assign p1_edge = p1_point & ~p1_q;
  assign p2_edge = p2_point & ~p2_q;

  bcd2_counter u_p1 (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (p1_inc),
    .tens    (dig1),
    .ones    (dig0),
    .value   (p1_val)
  );

  bcd2_counter u_p2 (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (p2_inc),
    .tens    (dig3),
    .ones    (dig2),
    .value   (p2_val)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    winner_d = winner_q;
    clr      = 1'b0;
    p1_inc   = 1'b0;
    p2_inc   = 1'b0;
    // Scores as they will be after this cycle's point, used by the win test.
    s1_new   = p1_edge ? sat_inc(p1_val) : p1_val;
    s2_new   = p2_edge ? sat_inc(p2_val) : p2_val;
    mine     = p1_edge ? s1_new : s2_new;
`ifdef PONG_DEUCE_EN
    opp      = p1_edge ? s2_new : s1_new;
    win      = (mine == SCORE_SAT) || ((mine >= WIN_VAL) && (mine >= opp + 7'd2));
`else
    win      = (mine >= WIN_VAL);
`endif

    if (new_game) begin
      clr      = 1'b1;
      hold_d   = '0;
      winner_d = 1'b0;
      state_d  = PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          // Simultaneous edges cancel each other out.
          if (p1_edge ^ p2_edge) begin
            p1_inc = p1_edge;
            p2_inc = p2_edge;
            if (win) begin
              state_d  = OVER;
              winner_d = (s2_new > s1_new);
            end else begin
              state_d = HOLD;
              hold_d  = HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (hold_q == '0) state_d = PLAY;
          else              hold_d  = hold_q - HOLD_W'(1);
        end
        default: ;
      endcase
    end

    serve_en_d  = (state_d == PLAY);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      p1_q        <= 1'b0;
      p2_q        <= 1'b0;
      serve_en_q  <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      p1_q        <= p1_point;
      p2_q        <= p2_point;
      serve_en_q  <= serve_en_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign serve_en  = serve_en_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_score_keeper.sv
// ============================================================================
// tb_pong_score_keeper : directed self-checking bench for pong_score_keeper
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_pong_score_keeper;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       new_game = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic       serve_en, game_over, winner;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pong_score_keeper #(.WIN_SCORE(11), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .new_game  (new_game),
    .p1_point  (p1_point),
    .p2_point  (p2_point),
    .dig0      (dig0),
    .dig1      (dig1),
    .dig2      (dig2),
    .dig3      (dig3),
    .serve_en  (serve_en),
    .game_over (game_over),
    .winner    (winner)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_play();
    int n = 0;
    while (!serve_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!serve_en) check("wait_play_timeout", 0, 1);
  endtask

  task automatic start_game();
    @(negedge clk); new_game = 1'b1;
    @(negedge clk); new_game = 1'b0;
    @(negedge clk);
  endtask

  // who: 0 = player 1, 1 = player 2; single-cycle pulse, then settle into HOLD.
  task automatic pulse(input bit who);
    @(negedge clk);
    if (who) p2_point = 1'b1; else p1_point = 1'b1;
    @(negedge clk);
    p1_point = 1'b0;
    p2_point = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic score(input bit who);
    wait_play();
    pulse(who);
  endtask

  initial begin
    int lows;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dig0", dig0, 0);
    check("rst_dig3", dig3, 0);
    check("rst_serve", serve_en, 0);
    check("rst_over", game_over, 0);
    check("rst_winner", winner, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_serve", serve_en, 0);

    // Held point counts once; HOLD length measured via serve_en
    start_game();
    check("ng_serve", serve_en, 1);
    p1_point = 1'b1;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!serve_en) lows++;
    end
    p1_point = 1'b0;
    check("held_dig0", dig0, 1);
    check("held_dig1", dig1, 0);
    check("hold_len", lows, HOLD);
    check("held_serve", serve_en, 1);

    // Ten p1 points: ones wraps into tens
    start_game();
    for (int i = 1; i <= 10; i++) begin
      score(1'b0);
      check("step_dig0", dig0, i % 10);
    end
    check("ten_dig1", dig1, 1);
    check("ten_bin", dut.p1_val, 10);
    check("ten_p2", dig2, 0);

    // Simultaneous edges at 03:04
    start_game();
    repeat (3) score(1'b0);
    repeat (4) score(1'b1);
    wait_play();
    @(negedge clk);
    p1_point = 1'b1;
    p2_point = 1'b1;
    @(negedge clk);
    check("sim_serve_a", serve_en, 1);
    p1_point = 1'b0;
    p2_point = 1'b0;
    repeat (3) @(negedge clk);
    check("sim_dig0", dig0, 3);
    check("sim_dig2", dig2, 4);
    check("sim_serve", serve_en, 1);

    // Asynchronous reset mid-game at 05:03
    start_game();
    repeat (5) score(1'b0);
    repeat (3) score(1'b1);
    check("pre_dig0", dig0, 5);
    check("pre_dig2", dig2, 3);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("arst_dig0", dig0, 0);
    check("arst_dig2", dig2, 0);
    check("arst_serve", serve_en, 0);
    check("arst_over", game_over, 0);
    check("arst_state", dut.state_q, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Player 2 reaches 11 from IDLE
    start_game();
    repeat (10) score(1'b1);
    check("p2_10_over", game_over, 0);
    score(1'b1);
    check("p2w_over", game_over, 1);
    check("p2w_winner", winner, 1);
    check("p2w_serve", serve_en, 0);
    check("p2w_dig3", dig3, 1);
    check("p2w_dig2", dig2, 1);
    pulse(1'b0);
    pulse(1'b1);
    check("over_ign_p1", dig0, 0);
    check("over_ign_p2", dig2, 1);
    check("over_hold", game_over, 1);
    start_game();
    check("rs_dig2", dig2, 0);
    check("rs_dig3", dig3, 0);
    check("rs_over", game_over, 0);
    check("rs_winner", winner, 0);
    check("rs_serve", serve_en, 1);

    // 10:10 then player 1 scores
    start_game();
    for (int i = 0; i < 10; i++) begin
      score(1'b0);
      score(1'b1);
    end
    check("tie_dig1", dig1, 1);
    check("tie_dig3", dig3, 1);
    score(1'b0);
`ifdef PONG_DEUCE_EN
    check("d11_over", game_over, 0);
    check("d11_dig0", dig0, 1);
    score(1'b0);
    check("d12_over", game_over, 1);
    check("d12_winner", winner, 0);
    check("d12_dig0", dig0, 2);
`else
    check("n11_over", game_over, 1);
    check("n11_winner", winner, 0);
    check("n11_dig0", dig0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
